// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - geometry, FSM encodings and address-field helpers for dcache_2way
package dcache_pkg;

  localparam int CACHE_SETS       = 16;
  localparam int CACHE_LINE_WORDS = 4;
  localparam int CACHE_ADDR_W     = 32;

  localparam int OFF_W  = $clog2(CACHE_LINE_WORDS);
  localparam int IDX_W  = $clog2(CACHE_SETS);
  localparam int TAG_W  = CACHE_ADDR_W - IDX_W - OFF_W - 2;
  localparam int LINE_W = 32 * CACHE_LINE_WORDS;

  // FSM encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [CACHE_ADDR_W-1:0] a);
    return a[CACHE_ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [CACHE_ADDR_W-1:0] a);
    return a[2+OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [CACHE_ADDR_W-1:0] a);
    return a[2 +: OFF_W];
  endfunction

endpackage

// File: rtl/dcache_2way_if.sv
// rtl/dcache_2way_if.sv - backing-memory port of dcache_2way
//   mem_req/mem_we/mem_addr/mem_wdata : cache -> memory (master drives)
//   mem_ack/mem_rdata                 : memory -> cache (one-cycle ack, full refill line)
interface dcache_2way_if;
  import dcache_pkg::*;

  logic                    mem_req;
  logic                    mem_we;
  logic [CACHE_ADDR_W-1:0] mem_addr;
  logic [31:0]             mem_wdata;
  logic                    mem_ack;
  logic [LINE_W-1:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/dcache_way.sv
// rtl/dcache_way.sv - one way of the cache: valid, tag and data arrays
//   idx/tag/off        : decoded request address fields
//   hit/vld/rdata      : combinational lookup results for the addressed set
//   line_we/line_data  : install a full line (sets valid and tag)
//   word_we/word_data  : overwrite one word of a resident line
module dcache_way
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  tag,
  input  logic [OFF_W-1:0]  off,
  output logic              hit,
  output logic              vld,
  output logic [31:0]       rdata,
  input  logic              line_we,
  input  logic [LINE_W-1:0] line_data,
  input  logic              word_we,
  input  logic [31:0]       word_data
);

  logic [CACHE_SETS-1:0] valid;
  logic [TAG_W-1:0]      tag_mem  [CACHE_SETS];
  logic [LINE_W-1:0]     data_mem [CACHE_SETS];

  assign vld   = valid[idx];
  assign hit   = valid[idx] && (tag_mem[idx] == tag);
  assign rdata = data_mem[idx][{off, 5'b0} +: 32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (line_we) begin
      valid[idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= line_data;
    end else if (word_we) begin
      data_mem[idx][{off, 5'b0} +: 32] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_2way.sv
// rtl/dcache_2way.sv - two-way write-through, no-write-allocate data cache
//   clk/rst              : clock, asynchronous active-low reset
//   i_req/i_addr/dataW/memRW : access-stage request (held stable while o_stall)
//   o_data/o_stall       : read data (0-cycle on hit), pipeline freeze
//   mem                  : backing-memory port (line refill / word write)
module dcache_2way
  import dcache_pkg::*;
#(
  parameter int SETS       = CACHE_SETS,
  parameter int LINE_WORDS = CACHE_LINE_WORDS,
  parameter int ADDR_W     = CACHE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       dataW,
  input  logic              memRW,
  output logic [31:0]       o_data,
  output logic              o_stall,
  dcache_2way_if.master     mem
);

  localparam int LINE_BITS = 32 * LINE_WORDS;

  logic [1:0]           state;
  logic [SETS-1:0]      lru;      // names the least-recently-used way per set
  logic                 victim;   // way being refilled, latched at miss

  logic [TAG_W-1:0]     tag;
  logic [IDX_W-1:0]     idx;
  logic [OFF_W-1:0]     off;

  logic                 hit0, hit1, vld0, vld1;
  logic [31:0]          rd0, rd1;
  logic                 hit, hit_way, victim_sel;
  logic                 idle, is_read, is_write, refill_done;
  logic [LINE_BITS-1:0] line_data;
  logic                 unused;

  assign tag = addr_tag(i_addr);
  assign idx = addr_idx(i_addr);
  assign off = addr_off(i_addr);
  assign unused = ^i_addr[1:0];

  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  assign idle     = (state == ST_IDLE);
  assign is_read  = i_req & ~memRW;
  assign is_write = i_req & memRW;
  assign refill_done = (state == ST_REFILL) & mem.mem_ack;
  assign line_data   = mem.mem_rdata;

  // Invalid way first (way0 preferred), otherwise the LRU way.
  assign victim_sel = !vld0 ? 1'b0 : (!vld1 ? 1'b1 : lru[idx]);

  dcache_way u_way0 (
    .clk(clk), .rst(rst), .idx(idx), .tag(tag), .off(off),
    .hit(hit0), .vld(vld0), .rdata(rd0),
    .line_we(refill_done & ~victim), .line_data(line_data),
    .word_we(idle & is_write & hit0), .word_data(dataW)
  );

  dcache_way u_way1 (
    .clk(clk), .rst(rst), .idx(idx), .tag(tag), .off(off),
    .hit(hit1), .vld(vld1), .rdata(rd1),
    .line_we(refill_done & victim), .line_data(line_data),
    .word_we(idle & is_write & hit1), .word_data(dataW)
  );

  always_comb begin
    o_stall = 1'b0;
    case (state)
      ST_IDLE:   o_stall = i_req & (memRW | ~hit);
      ST_REFILL: o_stall = 1'b1;
      ST_WRITE:  o_stall = ~mem.mem_ack;  // released in the ack cycle
      default:   o_stall = 1'b0;
    endcase
  end

  assign o_data = (idle & is_read & hit) ? (hit_way ? rd1 : rd0) : 32'd0;

  // Memory port is decoded from state; the request fields are held upstream.
  assign mem.mem_req   = (state == ST_REFILL) | (state == ST_WRITE);
  assign mem.mem_we    = (state == ST_WRITE);
  assign mem.mem_wdata = (state == ST_WRITE) ? dataW : 32'd0;

  always_comb begin
    mem.mem_addr = '0;
    case (state)
      ST_REFILL: mem.mem_addr = {i_addr[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
      ST_WRITE:  mem.mem_addr = {i_addr[ADDR_W-1:2], 2'b00};
      default:   mem.mem_addr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      lru    <= '0;
      victim <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_read) begin
            if (hit) begin
              lru[idx] <= ~hit_way;
            end else begin
              victim <= victim_sel;
              state  <= ST_REFILL;
            end
          end else if (is_write) begin
            if (hit) lru[idx] <= ~hit_way;
            state <= ST_WRITE;
          end
        end
        ST_REFILL: begin
          if (mem.mem_ack) begin
            lru[idx] <= ~victim;
            state    <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (mem.mem_ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_2way.sv
// tb/tb_dcache_2way.sv - directed vector bench for dcache_2way
module tb_dcache_2way;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] dataW;
  logic        memRW;
  logic [31:0] o_data;
  logic        o_stall;

  int total = 0;
  int bad   = 0;

  dcache_2way_if mif ();

  dcache_2way dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .dataW(dataW),
    .memRW(memRW), .o_data(o_data), .o_stall(o_stall), .mem(mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rw;
    logic        ack;
    logic [127:0] rdata;
    logic        stall;
    logic [31:0] data;
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
  } vec_t;

  vec_t vq[$];

  function automatic logic [127:0] ln(input logic [31:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic vec_t mk(input logic req, input logic [31:0] addr, wd,
                              input logic rw, ack, input logic [127:0] rdata,
                              input logic stall, input logic [31:0] data,
                              input logic mreq, mwe, input logic [31:0] maddr, mwdata);
    vec_t v;
    v.req = req; v.addr = addr; v.wd = wd; v.rw = rw; v.ack = ack; v.rdata = rdata;
    v.stall = stall; v.data = data; v.mreq = mreq; v.mwe = mwe;
    v.maddr = maddr; v.mwdata = mwdata;
    return v;
  endfunction

  task automatic drive(input logic req, input logic [31:0] addr, wd,
                       input logic rw, ack, input logic [127:0] rdata);
    i_req = req; i_addr = addr; dataW = wd; memRW = rw;
    mif.mem_ack = ack; mif.mem_rdata = rdata;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [127:0] la, lb, lc, ld, le, lf, lg;
    la = ln(32'd1, 32'd2, 32'd3, 32'd4);
    lb = ln(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    lc = ln(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    ld = ln(32'hC0, 32'hC1, 32'hC2, 32'hC3);
    le = ln(32'hE0, 32'hE1, 32'hE2, 32'hE3);
    lf = ln(32'hD0, 32'hD1, 32'hD2, 32'hD3);
    lg = ln(32'hF0, 32'hF1, 32'hF2, 32'hF3);

    //            req addr      wd          rw ack rdata | stall data        mreq mwe maddr   mwdata
    vq.push_back(mk(1, 32'h100, 0,          0, 0, 0,    1, 0,           0, 0, 0,        0));
    vq.push_back(mk(1, 32'h100, 0,          0, 1, la,   1, 0,           1, 0, 32'h100,  0));
    vq.push_back(mk(1, 32'h100, 0,          0, 0, 0,    0, 1,           0, 0, 0,        0));
    vq.push_back(mk(1, 32'h10C, 0,          0, 0, 0,    0, 4,           0, 0, 0,        0));
    vq.push_back(mk(1, 32'h000, 0,          0, 0, 0,    1, 0,           0, 0, 0,        0));
    vq.push_back(mk(1, 32'h000, 0,          0, 1, lb,   1, 0,           1, 0, 32'h000,  0));
    vq.push_back(mk(1, 32'h000, 0,          0, 0, 0,    0, 32'hA0,      0, 0, 0,        0));
    vq.push_back(mk(1, 32'h200, 0,          0, 0, 0,    1, 0,           0, 0, 0,        0));
    vq.push_back(mk(1, 32'h200, 0,          0, 1, lc,   1, 0,           1, 0, 32'h200,  0));
    vq.push_back(mk(1, 32'h200, 0,          0, 0, 0,    0, 32'hB0,      0, 0, 0,        0));
    vq.push_back(mk(1, 32'h004, 0,          0, 0, 0,    0, 32'hA1,      0, 0, 0,        0));
    vq.push_back(mk(1, 32'h100, 0,          0, 0, 0,    1, 0,           0, 0, 0,        0));
    vq.push_back(mk(1, 32'h100, 0,          0, 1, la,   1, 0,           1, 0, 32'h100,  0));
    vq.push_back(mk(1, 32'h100, 0,          0, 0, 0,    0, 1,           0, 0, 0,        0));
    vq.push_back(mk(1, 32'h104, 32'hDEADBEEF, 1, 0, 0,  1, 0,           0, 0, 0,        0));
    vq.push_back(mk(1, 32'h104, 32'hDEADBEEF, 1, 0, 0,  1, 0,           1, 1, 32'h104,  32'hDEADBEEF));
    vq.push_back(mk(1, 32'h104, 32'hDEADBEEF, 1, 1, 0,  0, 0,           1, 1, 32'h104,  32'hDEADBEEF));
    vq.push_back(mk(1, 32'h104, 0,          0, 0, 0,    0, 32'hDEADBEEF, 0, 0, 0,       0));
    vq.push_back(mk(1, 32'h300, 32'h12345678, 1, 0, 0,  1, 0,           0, 0, 0,        0));
    vq.push_back(mk(1, 32'h300, 32'h12345678, 1, 1, 0,  0, 0,           1, 1, 32'h300,  32'h12345678));
    vq.push_back(mk(1, 32'h300, 0,          0, 0, 0,    1, 0,           0, 0, 0,        0));
    vq.push_back(mk(1, 32'h300, 0,          0, 1, ld,   1, 0,           1, 0, 32'h300,  0));
    vq.push_back(mk(1, 32'h300, 0,          0, 0, 0,    0, 32'hC0,      0, 0, 0,        0));
    vq.push_back(mk(0, 32'h000, 0,          0, 1, le,   0, 0,           0, 0, 0,        0));
    vq.push_back(mk(1, 32'h30C, 0,          0, 0, 0,    0, 32'hC3,      0, 0, 0,        0));
    vq.push_back(mk(1, 32'h418, 0,          0, 0, 0,    1, 0,           0, 0, 0,        0));
    vq.push_back(mk(1, 32'h418, 0,          0, 0, 0,    1, 0,           1, 0, 32'h410,  0));
    vq.push_back(mk(1, 32'h418, 0,          0, 1, lf,   1, 0,           1, 0, 32'h410,  0));
    vq.push_back(mk(1, 32'h418, 0,          0, 0, 0,    0, 32'hD2,      0, 0, 0,        0));

    // Reset state
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst mem_req",   {31'd0, mif.mem_req}, 0);
    chk("rst mem_we",    {31'd0, mif.mem_we},  0);
    chk("rst mem_addr",  mif.mem_addr,         0);
    chk("rst mem_wdata", mif.mem_wdata,        0);
    chk("rst o_data",    o_data,               0);
    chk("rst o_stall",   {31'd0, o_stall},     0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Cycle-by-cycle vector table
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].req, vq[i].addr, vq[i].wd, vq[i].rw, vq[i].ack, vq[i].rdata);
      #1;
      chk($sformatf("v%0d o_stall", i),   {31'd0, o_stall},     {31'd0, vq[i].stall});
      chk($sformatf("v%0d o_data", i),    o_data,               vq[i].data);
      chk($sformatf("v%0d mem_req", i),   {31'd0, mif.mem_req}, {31'd0, vq[i].mreq});
      chk($sformatf("v%0d mem_we", i),    {31'd0, mif.mem_we},  {31'd0, vq[i].mwe});
      chk($sformatf("v%0d mem_addr", i),  mif.mem_addr,         vq[i].maddr);
      chk($sformatf("v%0d mem_wdata", i), mif.mem_wdata,        vq[i].mwdata);
    end

    // Reset in the middle of a refill
    @(negedge clk);
    drive(1, 32'h500, 0, 0, 0, 0);
    #1;
    chk("mr miss stall", {31'd0, o_stall}, 1);
    @(negedge clk);
    #1;
    chk("mr refill req",  {31'd0, mif.mem_req}, 1);
    chk("mr refill addr", mif.mem_addr, 32'h500);
    rst = 1'b0;
    #1;
    chk("mr req dropped", {31'd0, mif.mem_req}, 0);
    chk("mr we dropped",  {31'd0, mif.mem_we},  0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 1, le);
    #1;
    chk("mr late ack req",   {31'd0, mif.mem_req}, 0);
    chk("mr late ack stall", {31'd0, o_stall},     0);
    @(negedge clk);
    drive(1, 32'h500, 0, 0, 0, 0);
    #1;
    chk("mr re-miss stall", {31'd0, o_stall}, 1);
    chk("mr re-miss data",  o_data, 0);
    @(negedge clk);
    drive(1, 32'h500, 0, 0, 1, lg);
    #1;
    chk("mr refill2 req",  {31'd0, mif.mem_req}, 1);
    chk("mr refill2 addr", mif.mem_addr, 32'h500);
    @(negedge clk);
    drive(1, 32'h500, 0, 0, 0, 0);
    #1;
    chk("mr refill2 data",  o_data, 32'hF0);
    chk("mr refill2 stall", {31'd0, o_stall}, 0);
    @(negedge clk);
    drive(1, 32'h100, 0, 0, 0, 0);
    #1;
    chk("mr old line gone", {31'd0, o_stall}, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, la);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("mr final idle req", {31'd0, mif.mem_req}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_2way.md
# dcache_2way

Two-way set-associative, write-through, no-write-allocate data cache placed between the access stage and backing data memory. It takes the access-stage ALU address, store data and read/write strobe. Read hits complete combinationally in the same cycle. Misses and all stores raise a pipeline stall while a line-refill or word-write transaction runs on the backing-memory port.

## Interface
Parameters:
- SETS, 16, number of sets; power of two ≥ 2
- LINE_WORDS, 4, 32-bit words per line; power of two ≥ 2
- ADDR_W, 32, byte-address width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- i_req  input  1  access valid this cycle
- i_addr  input  ADDR_W  byte address; bits [1:0] ignored (word access only)
- dataW  input  32  store data
- memRW  input  1  1 = write, 0 = read
- o_data  output  32  read data; valid when i_req & !memRW & !o_stall
- o_stall  output  1  freeze pipeline; combinational
- mem_req  output  1  backing-memory request, held until mem_ack
- mem_we  output  1  1 = word write, 0 = line read
- mem_addr  output  ADDR_W  line-aligned for reads, word-aligned for writes
- mem_wdata  output  32  write word
- mem_ack  input  1  one-cycle completion pulse
- mem_rdata  input  32*LINE_WORDS  refill line; word w at bits [32w+31:32w]; sampled when mem_ack is high

## Operation
- Address split: offset = i_addr[2 +: log2(LINE_WORDS)], index = the next log2(SETS) bits, tag = the remaining upper bits.
- Hit: valid[way][index] is set and tag[way][index] equals the request tag. At most one way can hit.
- FSM states:
  - IDLE
    - Read hit: o_data = the hitting way's word; o_stall = 0; the LRU bit for the set is updated.
    - Read miss: o_stall = 1; select a victim; go to REFILL.
    - Write (hit or miss): o_stall = 1; go to WRITE. On a write hit, the cached word is updated in the same cycle and the LRU bit is updated.
  - REFILL
    - mem_req = 1, mem_we = 0, mem_addr = {tag, index, 0…}.
    - On mem_ack: write the whole line into the victim way, set valid, set tag, point LRU at the other way, go to IDLE.
    - The request is then re-evaluated in IDLE and hits.
  - WRITE
    - mem_req = 1, mem_we = 1, mem_addr = {i_addr[ADDR_W-1:2], 2'b00}, mem_wdata = dataW.
    - On mem_ack: go to IDLE with o_stall = 0 in that cycle. The store does not re-execute.
    - A write miss does not allocate a line.
- Victim selection: an invalid way first, way0 preferred over way1; otherwise the way indicated by LRU. There is one LRU bit per set; it names the least-recently-used way.
- o_stall is 1 in REFILL, and in WRITE until the mem_ack cycle. It is 0 whenever i_req = 0 in IDLE.
- While o_stall = 1, the upstream stage holds i_addr, dataW and memRW stable.
- A mem_ack received in IDLE is ignored.

## Timing
- Reset (asserted, asynchronous):
  - All valid bits = 0 and all LRU bits = 0.
  - FSM = IDLE; mem_req = 0, mem_we = 0.
  - mem_addr and mem_wdata = 0; o_data = 0; o_stall = 0.
  - Tag and data arrays are not reset.
- Read hit: 0-cycle latency.
- Read miss: o_stall is high from the request cycle through the mem_ack cycle. Data is returned in the cycle after mem_ack; the minimum total latency is 2 cycles.
- Write: o_stall is high from the request cycle up to, but not including, the mem_ack cycle. The minimum latency is 1 extra cycle.
- mem_req rises on the clock edge after the miss or write is detected. It falls on the edge after mem_ack.
- A mem_ack arriving in the same cycle that mem_req first asserts is accepted.
- Reset asserted mid-REFILL or mid-WRITE aborts the transaction: mem_req drops immediately and any in-flight refill data is discarded.

## Structure
- Package dcache_pkg holds:
  - the state enum (IDLE, REFILL, WRITE);
  - the width localparams: OFF_W, IDX_W, TAG_W;
  - the field-extraction functions for tag, index and offset.
- Sub-module dcache_way, instantiated twice, holds one way's valid, tag and data arrays. It provides:
  - combinational hit and read word outputs;
  - a line-write port and a word-write port.
- The top level holds the LRU array, the FSM, victim selection and the backing-memory port.

## Test plan
- Reset, then read 0x100 → o_stall = 1 and mem_req with mem_addr = 0x100. Return mem_ack with line {4,3,2,1} → o_data = 1 the cycle after the ack, o_stall = 0.
- After a refill of the line at 0x100, read 0x10C → o_data = 4 in the same cycle, no mem_req.
- Fill set 0 with 0x000 and 0x100, touch 0x000, then read 0x200 → 0x100's way is evicted. A following read of 0x000 hits; a read of 0x100 misses.
- Write 0xDEADBEEF to 0x104 on a hit → mem_req with mem_we = 1, mem_addr = 0x104 until ack. A subsequent read of 0x104 hits and returns 0xDEADBEEF.
- Write to uncached 0x300 → one memory write, no refill. The next read of 0x300 misses.
- Assert rst during REFILL before mem_ack → mem_req = 0 immediately. A late mem_ack is ignored, and a read of the same address misses again.
